// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between N requesters.
// Captures the winner's operands, issues Start, follows Ready and returns the product.
module mult_share_arbiter #(
    parameter int N            = 2,
    parameter int W            = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic [N-1:0]       req,
    input  logic [N*W-1:0]     multiplicand_in,
    input  logic [N*W-1:0]     multiplier_in,
    output logic [N-1:0]       grant,
    output logic [N-1:0]       done,
    output logic [N-1:0]       err,
    output logic [2*W-1:0]     product_out,
    output logic               mult_start,
    output logic [W-1:0]       mult_multiplicand,
    output logic [W-1:0]       mult_multiplier,
    input  logic [2*W-1:0]     mult_product,
    input  logic               mult_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W-1:0]       mcand_q, mcand_d;
    logic [W-1:0]       mplier_q, mplier_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic [N-1:0]       err_q, err_d;

    logic               found;
    logic [IW-1:0]      pick;
    logic [W-1:0]       pickA;
    logic [W-1:0]       pickB;
    logic [IW-1:0]      nextIdx;
    int                 arbPos;

    // Scan requesters starting at the round-robin pointer, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        pick   = '0;
        pickA  = '0;
        pickB  = '0;
        arbPos = 0;
        for (int k = 0; k < N; k++) begin
            arbPos = int'(rr_q) + k;
            if (arbPos >= N) begin
                arbPos = arbPos - N;
            end
            if (!found && req[arbPos]) begin
                found = 1'b1;
                pick  = IW'(arbPos);
                pickA = multiplicand_in[arbPos*W +: W];
                pickB = multiplier_in[arbPos*W +: W];
            end
        end
    end

    assign nextIdx = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        err_d      = '0;
        mult_start = 1'b0;
        grant      = '0;
        done       = '0;
        case (state_q)
            IDLE: begin
                if (found && mult_ready) begin
                    idx_d    = pick;
                    mcand_d  = pickA;
                    mplier_d = pickB;
                    state_d  = START;
                end
            end
            START: begin
                mult_start   = 1'b1;
                grant[idx_q] = 1'b1;
                cnt_d        = '0;
                state_d      = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A multiplier that never drops Ready would otherwise lock the arbiter forever.
                if (!mult_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(BUSY_TIMEOUT)) begin
                        err_d[idx_q] = 1'b1;
                        rr_d         = nextIdx;
                        state_d      = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (mult_ready) begin
                    prod_d  = mult_product;
                    state_d = DONE;
                end
            end
            DONE: begin
                done[idx_q] = 1'b1;
                rr_d        = nextIdx;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    assign err               = err_q;
    assign product_out       = prod_q;
    assign mult_multiplicand = mcand_q;
    assign mult_multiplier   = mplier_q;

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one Sequential_Binary_Multiplier between N requesters using round-robin arbitration.
- Captures the winning requester's operands and issues a single-cycle Start.
- Tracks the multiplier's Ready busy/done handshake and returns the product to the winning requester with a done pulse.
- Sits between requesting blocks and the multiplier instance; it is the multiplier's only driver.

Parameters:
- N, 2, number of requesters (2..8).
- W, 4, operand width; matches the multiplier's dp_width.
- BUSY_TIMEOUT, 4, cycles allowed for mult_ready to fall after mult_start before an error is declared.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level; held until done or err for that requester.
- multiplicand_in  in  N*W  packed operands; slice i belongs to requester i.
- multiplier_in  in  N*W  packed operands; slice i belongs to requester i.
- grant  out  N  one-hot; high during the START cycle for the winner.
- done  out  N  one-hot, 1-cycle pulse; product_out is valid.
- err  out  N  one-hot, 1-cycle pulse; BUSY_TIMEOUT expired.
- product_out  out  2W  last product; holds until the next done.
- mult_start  out  1  to multiplier Start.
- mult_multiplicand  out  W  registered operand to multiplier.
- mult_multiplier  out  W  registered operand to multiplier.
- mult_product  in  2W  multiplier Product.
- mult_ready  in  1  multiplier Ready (high = idle/done).

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low, ports named clock and reset_b.
- Reset values: all outputs 0, state IDLE, rr pointer 0, timeout counter 0.
- IDLE: if any req is set and mult_ready=1, pick the first set req at or after the rr pointer, wrapping modulo N. Register its index, register its operands onto mult_multiplicand/mult_multiplier, go to START. Otherwise stay in IDLE. Operands are sampled only here; later changes on the inputs are ignored.
- START (1 cycle): mult_start=1 and grant[idx]=1. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - mult_ready=0 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, pulse err[idx], set rr pointer = idx+1 mod N, go to IDLE.
- WAIT_DONE: on the first cycle with mult_ready=1, register mult_product into product_out and go to DONE.
- DONE (1 cycle): done[idx]=1. Set rr pointer = idx+1 mod N. Go to IDLE.
- Minimum service latency, req edge to done pulse: 3 + (multiplier busy cycles) cycles. No new request is granted in the DONE cycle.
- mult_start is never high for more than one consecutive cycle. grant, done and err are each at most one-hot.
- Operand registers hold their value from START through DONE. They may hold stale values in IDLE.
- Request dropped:
  - A req dropped before grant is simply not served.
  - A req dropped after grant does not abort the operation; done is still pulsed.
- Simultaneous requests resolve strictly by the rr pointer. With every req held high, grants rotate 0,1,…,N-1,0.
- Asynchronous reset mid-operation: returns everything to the reset values immediately. The multiplier is reset by the same reset_b, so no partial result is delivered.
- Unused states decode to IDLE.

Test Plan:
- Use N=2, W=4, the real multiplier, and a 10-unit clock.
- Single request: req=01, operands 8×9 → one mult_start pulse, grant=01 for 1 cycle, then done=01 pulse with product_out=8'h48 (72). Product holds afterwards.
- Simultaneous requests after reset: req=11, requester0 = 3×5, requester1 = 15×15 → requester0 is served first (product 15), then requester1 (product 225 = 8'hE1). No overlap of mult_start.
- Continuous contention: both req held high for 4 operations → grant sequence 01,10,01,10. A done precedes every next grant.
- Withdrawal:
  - req0 pulsed low before IDLE samples it → no grant to requester0.
  - req1 dropped after its grant → done[1] still pulses with the correct product.
- Reset mid-WAIT_DONE: assert reset_b=0 while busy → all outputs 0 asynchronously. After release, req=10 with 7×6 → grant=10 (pointer reset to 0, requester0 idle), product 42.
- Timeout: stub mult_ready stuck at 1 → err pulses for the winner exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry, with no done. The next request is arbitrated normally.
